axis_source_scheduler: RTL and testbench

// - Shares the single packet-to-AXIS packer (data/data_valid/data_next interface) between NUM_SRC packet producers.
// - Round-robin arbitration with burst lock: a granted source keeps ownership for BURST_LEN packets, so every packer ping-pong buffer holds one source.
// - Idle timeout releases a stalled owner. Sits between the core-side packet generators and the packer, in the C2H clock domain.

---
 rtl/axis_dma_pkg.sv | 21 ++
 rtl/rr_arbiter_pick.sv | 37 +++
 rtl/axis_source_scheduler.sv | 145 ++++++++++++++
 tb/tb_axis_source_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dma_pkg.sv
// Shared definitions for the AXIS DMA source scheduling logic.
// Scheduler state encodings and a wrapping index helper.
package axis_dma_pkg;

    localparam int NUM_SRC_MAX = 8;
    localparam int GID_W       = 3;
    localparam int TIMEOUT_W   = 8;
    localparam int TCNT_W      = 16;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t SCHED_IDLE    = 2'd0;
    localparam sched_state_t SCHED_BURST   = 2'd1;
    localparam sched_state_t SCHED_RELEASE = 2'd2;

    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] idx,
                                                  input logic [GID_W-1:0] last);
        return (idx == last) ? '0 : idx + GID_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first eligible index at or above rr_ptr_i,
// wrapping through NUM_SRC-1 back to 0.
module rr_arbiter_pick
    import axis_dma_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] elig_i,
    input  logic [GID_W-1:0]   rr_ptr_i,
    output logic [GID_W-1:0]   winner_o,
    output logic               any_o
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [GID_W:0]       sum;

    assign dbl = {elig_i, elig_i};

    // rot[0] is the source rr_ptr_i points at; descending scan keeps the lowest hit
    always_comb begin
        rot      = NUM_SRC'(dbl >> rr_ptr_i);
        winner_o = '0;
        sum      = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, rr_ptr_i} + (GID_W+1)'(i);
                if (sum >= (GID_W+1)'(NUM_SRC)) begin
                    sum = sum - (GID_W+1)'(NUM_SRC);
                end
                winner_o = sum[GID_W-1:0];
            end
        end
        any_o = |elig_i;
    end

endmodule

// File: rtl/axis_source_scheduler.sv
// Shares one packet-to-AXIS packer between NUM_SRC producers: round-robin
// grants locked for BURST_LEN packets, with an idle timeout for stalled owners.
//
//   state         | meaning
//   SCHED_IDLE    | arbitrate among masked valid sources when enabled
//   SCHED_BURST   | owner drives the packer until BURST_LEN transfers or timeout
//   SCHED_RELEASE | one dead cycle, advance rr_ptr past the last owner
module axis_source_scheduler
    import axis_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 16000,
    parameter int NUM_SRC    = 4,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          m_axis_c2h_aclk,
    input  logic                          m_axis_c2h_areset,
    input  logic                          sched_en,
    input  logic [NUM_SRC-1:0]            src_mask,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          data_valid,
    input  logic                          data_next,
    output logic [GID_W-1:0]              grant_id,
    output logic                          busy,
    output logic [TCNT_W-1:0]             timeout_cnt
);

    localparam int BCNT_W = $clog2(BURST_LEN) + 1;
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BASE_W = $clog2(NUM_SRC * DATA_WIDTH);

    localparam logic [BCNT_W-1:0]    BURST_LAST = BCNT_W'(BURST_LEN - 1);
    localparam logic [TIMEOUT_W-1:0] IDLE_LAST  = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [GID_W-1:0]     SRC_LAST   = GID_W'(NUM_SRC - 1);

    sched_state_t          state_q, state_d;
    logic [GID_W-1:0]      grant_id_q, grant_id_d;
    logic [GID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [TIMEOUT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [TCNT_W-1:0]     timeout_cnt_q, timeout_cnt_d;

    logic [NUM_SRC-1:0]    elig;
    logic [GID_W-1:0]      pick_winner;
    logic                  pick_any;
    logic [SEL_W-1:0]      grant_sel;
    logic [BASE_W-1:0]     data_base;
    logic                  owner_valid;

    assign elig        = src_mask & src_valid;
    assign grant_sel   = grant_id_q[SEL_W-1:0];
    assign owner_valid = src_valid[grant_sel];
    assign data_base   = BASE_W'(grant_sel) * BASE_W'(DATA_WIDTH);

    rr_arbiter_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .elig_i   (elig),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (pick_winner),
        .any_o    (pick_any)
    );

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (m_axis_c2h_areset) begin
            state_q       <= SCHED_IDLE;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            idle_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            SCHED_IDLE: begin
                if (sched_en && pick_any) begin
                    grant_id_d  = pick_winner;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                    state_d     = SCHED_BURST;
                end
            end
            SCHED_BURST: begin
                if (owner_valid && data_next) begin
                    burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                    idle_cnt_d  = '0;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = SCHED_RELEASE;
                    end
                end else if (!owner_valid) begin
                    // packer back-pressure alone never counts toward the timeout
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = SCHED_RELEASE;
                        if (timeout_cnt_q != '1) begin
                            timeout_cnt_d = timeout_cnt_q + TCNT_W'(1);
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + TIMEOUT_W'(1);
                    end
                end
            end
            SCHED_RELEASE: begin
                rr_ptr_d = wrap_inc(grant_id_q, SRC_LAST);
                state_d  = SCHED_IDLE;
            end
            default: begin
                state_d = SCHED_IDLE;
            end
        endcase
    end

    always_comb begin
        src_ready  = '0;
        data       = '0;
        data_valid = 1'b0;
        if (state_q == SCHED_BURST) begin
            src_ready[grant_sel] = data_next;
            data                 = src_data[data_base +: DATA_WIDTH];
            data_valid           = owner_valid;
        end
    end

    assign grant_id    = grant_id_q;
    assign busy        = (state_q == SCHED_BURST);
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_axis_source_scheduler.sv
// Scoreboard bench for axis_source_scheduler: per-source packet models feed
// the DUT, expected transfers are queued by the stimulus and checked by a monitor.
module tb_axis_source_scheduler;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int BL = 8;
    localparam int TO = 10;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic              sched_en = 1'b1;
    logic [NS-1:0]     src_mask = '1;
    logic [NS-1:0]     src_valid = '0;
    logic [NS*DW-1:0]  src_data = '0;
    logic [NS-1:0]     src_ready;
    logic [DW-1:0]     data;
    logic              data_valid;
    logic              data_next = 1'b1;
    logic [2:0]        grant_id;
    logic              busy;
    logic [15:0]       timeout_cnt;

    always #5 clk = ~clk;

    axis_source_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .m_axis_c2h_aclk   (clk),
        .m_axis_c2h_areset (areset),
        .sched_en          (sched_en),
        .src_mask          (src_mask),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_ready         (src_ready),
        .data              (data),
        .data_valid        (data_valid),
        .data_next         (data_next),
        .grant_id          (grant_id),
        .busy              (busy),
        .timeout_cnt       (timeout_cnt)
    );

    typedef struct {
        int src;
        int seq;
        bit first;
        int gap;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            rem[NS];
    int            seq[NS];
    bit            bp_mode = 1'b0;
    int            cyc = 0;
    int            last_cyc = 0;
    bit            saw_idle = 1'b1;
    logic [NS-1:0] hs_v;

    function automatic logic [DW-1:0] pkt(input int s, input int q);
        return {4'(s), 12'(q)};
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void drive_srcs();
        for (int i = 0; i < NS; i++) begin
            src_valid[i]          = (rem[i] > 0);
            src_data[i*DW +: DW]  = pkt(i, seq[i]);
        end
    endfunction

    task automatic load(input int i, input int n);
        rem[i] = n;
        drive_srcs();
    endtask

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive_srcs();
    endtask

    task automatic push_burst(input int s, input int seq0, input int n,
                              input int gap_first, input int gap_rest);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.src   = s;
            e.seq   = seq0 + k;
            e.first = (k == 0);
            e.gap   = (k == 0) ? gap_first : gap_rest;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d transfers still pending after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(posedge clk);
        #2;
        areset = 1'b0;
        clear_src();
    endtask

    // Source models: a handshake seen before the edge advances that source's packet.
    initial forever begin
        @(negedge clk);
        hs_v = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs_v[i]) begin
                rem[i] = rem[i] - 1;
                seq[i] = seq[i] + 1;
            end
        end
        drive_srcs();
        data_next = bp_mode ? ~data_next : 1'b1;
    end

    // Monitor: every packer transfer is matched against the head of the queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (areset) begin
            saw_idle = 1'b1;
        end else begin
            if (data_valid && data_next) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: grant %0d data %0h, no transfer expected", grant_id, data);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data", data, pkt(e.src, e.seq));
                    check("xfer_grant", grant_id, e.src);
                    check("burst_start", saw_idle, e.first);
                    if (e.gap != 0) check("xfer_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
                saw_idle = 1'b0;
            end else begin
                if (data_valid && !data_next && exp_q.size() > 0)
                    check("hold_data", data, pkt(exp_q[0].src, exp_q[0].seq));
                if (!busy) saw_idle = 1'b1;
            end
            if (bp_mode && busy && src_valid != '0)
                check("bp_idle_cnt", dut.idle_cnt_q, 0);
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        idle(2);
        @(negedge clk);
        check("rst_src_ready", src_ready, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        check("rst_data", data, 0);
        @(posedge clk);
        #2;
        areset = 1'b0;

        // single source: one-cycle arbitration, two back-to-back bursts
        clear_src();
        push_burst(0, 0, 8, 0, 1);
        push_burst(0, 8, 8, 3, 1);
        load(0, 16);
        @(negedge clk);
        check("arb_cycle_busy", busy, 0);
        @(negedge clk);
        check("grant_busy", busy, 1);
        check("grant_id_src0", grant_id, 0);
        wait_drain("single_src", 60);
        idle(4);
        check("single_done_busy", busy, 0);

        // round robin across four continuously valid sources
        do_reset();
        push_burst(0, 0, 8, 0, 1);
        push_burst(1, 0, 8, 3, 1);
        push_burst(2, 0, 8, 3, 1);
        push_burst(3, 0, 8, 3, 1);
        push_burst(0, 8, 8, 3, 1);
        load(0, 16);
        load(1, 8);
        load(2, 8);
        load(3, 8);
        wait_drain("round_robin", 120);
        idle(4);
        check("rr_done_busy", busy, 0);

        // packer back-pressure inside a burst
        do_reset();
        push_burst(1, 0, 8, 0, 0);
        bp_mode = 1'b1;
        load(1, 8);
        wait_drain("backpressure", 60);
        bp_mode = 1'b0;
        idle(3);
        check("bp_burst_ended", busy, 0);
        idle(12);
        check("bp_no_timeout", timeout_cnt, 0);

        // idle timeout: source 2 stalls after 3 packets
        do_reset();
        push_burst(2, 0, 3, 0, 1);
        push_burst(3, 0, 8, 13, 1);
        push_burst(0, 0, 8, 3, 1);
        load(2, 3);
        @(posedge clk);
        #2;
        check("to_grant_src2", grant_id, 2);
        load(0, 8);
        load(3, 8);
        wait_drain("timeout", 100);
        check("timeout_cnt_one", timeout_cnt, 1);

        // mask: only sources 1 and 3 eligible
        do_reset();
        src_mask = 4'b1010;
        push_burst(1, 0, 8, 0, 1);
        push_burst(3, 0, 8, 3, 1);
        for (int i = 0; i < NS; i++) load(i, 8);
        wait_drain("mask", 80);
        idle(30);
        check("mask_idle_busy", busy, 0);
        clear_src();
        src_mask = '1;

        // sched_en dropped mid-burst: burst completes, no new grant
        do_reset();
        push_burst(0, 0, 8, 0, 1);
        load(0, 8);
        load(1, 8);
        begin
            int n;
            n = 0;
            while (exp_q.size() > 5 && n < 20) begin
                @(posedge clk);
                n++;
            end
            #2;
        end
        sched_en = 1'b0;
        wait_drain("en_burst_finish", 40);
        idle(20);
        check("en_off_idle", busy, 0);
        push_burst(1, 0, 8, 0, 1);
        sched_en = 1'b1;
        wait_drain("en_resume", 40);
        idle(3);

        // reset mid-burst after 4 transfers
        clear_src();
        push_burst(2, 0, 4, 0, 1);
        load(2, 4);
        wait_drain("pre_reset", 30);
        idle(2);
        check("mid_busy", busy, 1);
        check("mid_grant", grant_id, 2);
        areset = 1'b1;
        @(posedge clk);
        #2;
        areset = 1'b0;
        @(negedge clk);
        check("mrst_src_ready", src_ready, 0);
        check("mrst_data_valid", data_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_grant_id", grant_id, 0);
        @(posedge clk);
        #2;
        clear_src();
        push_burst(0, 0, 8, 0, 1);
        push_burst(1, 0, 8, 3, 1);
        load(0, 8);
        load(1, 8);
        wait_drain("post_reset", 60);
        idle(4);
        check("post_timeout_cnt", timeout_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
